// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition-code encodings,
// flag bit positions and the control FSM state type.
package branch_resolver_pkg;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GTE = 3'b100,
        CC_LTE = 3'b101,
        CC_OV  = 3'b110,
        CC_UNC = 3'b111
    } ccc_t;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational condition evaluator: reports whether a condition code holds
// for the given flags and which flags that condition depends on.
module cond_eval
    import branch_resolver_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true,
    output logic [2:0] used_mask
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        cond_true = 1'b0;
        used_mask = '0;
        case (ccc)
            CC_NE:  begin cond_true = !z;              used_mask[FLAG_Z] = 1'b1; end
            CC_EQ:  begin cond_true = z;               used_mask[FLAG_Z] = 1'b1; end
            CC_GT:  begin
                cond_true = !z && !n;
                used_mask[FLAG_Z] = 1'b1;
                used_mask[FLAG_N] = 1'b1;
            end
            CC_LT:  begin cond_true = n;               used_mask[FLAG_N] = 1'b1; end
            CC_GTE: begin
                cond_true = z || (!z && !n);
                used_mask[FLAG_Z] = 1'b1;
                used_mask[FLAG_N] = 1'b1;
            end
            CC_LTE: begin
                cond_true = z || n;
                used_mask[FLAG_Z] = 1'b1;
                used_mask[FLAG_N] = 1'b1;
            end
            CC_OV:  begin cond_true = v;               used_mask[FLAG_V] = 1'b1; end
            CC_UNC: begin cond_true = 1'b1; end
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: accepts one branch at a time, stalls while a flag it
// depends on is being written, then pulses the resolved fetch address.
module branch_resolver
    import branch_resolver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  ccc,
    input  logic [8:0]  br_imm,
    input  logic        br_reg_mode,
    input  logic [15:0] br_reg,
    input  logic [15:0] pc_in,
    input  logic [2:0]  flag_in,
    input  logic [2:0]  flag_wr_en,
    output logic        res_valid,
    output logic        taken,
    output logic [15:0] next_pc,
    output logic        flush
);

    state_t      state;
    logic [2:0]  cap_ccc;
    logic [8:0]  cap_imm;
    logic        cap_reg_mode;
    logic [15:0] cap_reg;
    logic [15:0] cap_pc;

    logic [2:0]  sel_ccc;
    logic [8:0]  sel_imm;
    logic        sel_reg_mode;
    logic [15:0] sel_reg;
    logic [15:0] sel_pc;

    logic        cond_true;
    logic [2:0]  used_mask;
    logic        stall;
    logic        resolve_now;
    logic [15:0] pc_plus2;
    logic [15:0] br_target;
    logic [15:0] resolved_pc;

    // In IDLE the live request is evaluated so a hazard-free branch resolves
    // at the accept edge; in WAIT the captured request is re-checked.
    always_comb begin
        if (state == ST_IDLE) begin
            sel_ccc      = ccc;
            sel_imm      = br_imm;
            sel_reg_mode = br_reg_mode;
            sel_reg      = br_reg;
            sel_pc       = pc_in;
        end else begin
            sel_ccc      = cap_ccc;
            sel_imm      = cap_imm;
            sel_reg_mode = cap_reg_mode;
            sel_reg      = cap_reg;
            sel_pc       = cap_pc;
        end
    end

    cond_eval u_cond_eval (
        .ccc       (sel_ccc),
        .flags     (flag_in),
        .cond_true (cond_true),
        .used_mask (used_mask)
    );

    assign stall       = |(flag_wr_en & used_mask);
    assign pc_plus2    = sel_pc + 16'd2;
    assign br_target   = sel_reg_mode ? sel_reg
                                      : pc_plus2 + {{6{sel_imm[8]}}, sel_imm, 1'b0};
    assign resolved_pc = cond_true ? br_target : pc_plus2;
    assign resolve_now = !stall && ((state == ST_WAIT) ||
                                    (state == ST_IDLE && br_valid));
    assign br_ready    = (state == ST_IDLE) && !rst;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            res_valid    <= 1'b0;
            taken        <= 1'b0;
            flush        <= 1'b0;
            next_pc      <= '0;
            // NOTE: the captured request is cleared too, so no stale branch survives a reset.
            cap_ccc      <= '0;
            cap_imm      <= '0;
            cap_reg_mode <= 1'b0;
            cap_reg      <= '0;
            cap_pc       <= '0;
        end else begin
            res_valid <= 1'b0;
            taken     <= 1'b0;
            flush     <= 1'b0;
            next_pc   <= '0;

            case (state)
                ST_IDLE: begin
                    if (br_valid) begin
                        cap_ccc      <= ccc;
                        cap_imm      <= br_imm;
                        cap_reg_mode <= br_reg_mode;
                        cap_reg      <= br_reg;
                        cap_pc       <= pc_in;
                        state        <= stall ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (!stall) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (resolve_now) begin
                res_valid <= 1'b1;
                taken     <= cond_true;
                flush     <= cond_true;
                next_pc   <= resolved_pc;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed corner cases plus
// randomized branches against a cycle-count/arithmetic reference model.
module tb_branch_resolver;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  ccc;
    logic [8:0]  br_imm;
    logic        br_reg_mode;
    logic [15:0] br_reg;
    logic [15:0] pc_in;
    logic [2:0]  flag_in;
    logic [2:0]  flag_wr_en;
    logic        res_valid;
    logic        taken;
    logic [15:0] next_pc;
    logic        flush;

    int n_checks;
    int n_fail;

    // Per-cycle flag activity relative to the accept cycle (index 0).
    logic [2:0]  wr_seq [8];
    logic [2:0]  flg_seq[8];
    logic [15:0] last_npc;
    logic        last_taken;

    branch_resolver dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .ccc         (ccc),
        .br_imm      (br_imm),
        .br_reg_mode (br_reg_mode),
        .br_reg      (br_reg),
        .pc_in       (pc_in),
        .flag_in     (flag_in),
        .flag_wr_en  (flag_wr_en),
        .res_valid   (res_valid),
        .taken       (taken),
        .next_pc     (next_pc),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags (Z=4, V=2, N=1) each condition reads.
    function automatic logic [2:0] model_mask(input logic [2:0] c);
        case (c)
            3'd0, 3'd1:       return 3'b100;
            3'd3:             return 3'b001;
            3'd2, 3'd4, 3'd5: return 3'b101;
            3'd6:             return 3'b010;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
        bit z = f[2];
        bit v = f[1];
        bit n = f[0];
        if (c == 3'd0) return !z;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z && !n;
        if (c == 3'd3) return n;
        if (c == 3'd4) return z || (!z && !n);
        if (c == 3'd5) return z || n;
        if (c == 3'd6) return v;
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_next_pc(input logic t, input logic [8:0] imm,
                                                  input logic mode, input logic [15:0] rg,
                                                  input logic [15:0] pc);
        int off;
        int seq;
        int tgt;
        off = imm[8] ? int'(imm) - 512 : int'(imm);
        seq = (int'(pc) + 2) % 65536;
        tgt = mode ? int'(rg) : (seq + off * 2 + 65536) % 65536;
        return t ? 16'(tgt) : 16'(seq);
    endfunction

    task automatic run_txn(input logic [2:0] c, input logic [8:0] imm, input logic mode,
                           input logic [15:0] rg, input logic [15:0] pc);
        int          ev;
        int          lat;
        logic        exp_t;
        logic [15:0] exp_pc;
        ev = 0;
        while (ev < 7 && (wr_seq[ev] & model_mask(c)) != 3'b000) ev++;
        lat    = ev + 1;
        exp_t  = model_taken(c, flg_seq[ev]);
        exp_pc = model_next_pc(exp_t, imm, mode, rg, pc);

        check("ready_at_accept", 32'(br_ready), 32'd1);
        br_valid    = 1'b1;
        ccc         = c;
        br_imm      = imm;
        br_reg_mode = mode;
        br_reg      = rg;
        pc_in       = pc;
        flag_in     = flg_seq[0];
        flag_wr_en  = wr_seq[0];

        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            step();
            flag_in    = (cyc < 8) ? flg_seq[cyc] : 3'b000;
            flag_wr_en = (cyc < 8) ? wr_seq[cyc]  : 3'b000;
            if (cyc == lat) begin
                check("res_valid", 32'(res_valid), 32'd1);
                check("taken", 32'(taken), 32'(exp_t));
                check("next_pc", 32'(next_pc), 32'(exp_pc));
                check("flush", 32'(flush), 32'(exp_t));
                last_npc   = next_pc;
                last_taken = taken;
            end else begin
                check("idle_outputs", {13'd0, res_valid, taken, flush, next_pc}, 32'd0);
            end
            if (cyc <= lat) begin
                check("ready_busy", 32'(br_ready), 32'd0);
                // Junk requests while busy must be ignored.
                br_valid    = 1'($urandom_range(1));
                ccc         = 3'($urandom);
                br_imm      = 9'($urandom);
                br_reg_mode = 1'($urandom_range(1));
                br_reg      = 16'($urandom);
                pc_in       = 16'($urandom);
            end else begin
                br_valid = 1'b0;
                check("ready_after", 32'(br_ready), 32'd1);
            end
        end
    endtask

    task automatic clear_seq();
        for (int i = 0; i < 8; i++) begin
            wr_seq[i]  = 3'b000;
            flg_seq[i] = 3'b000;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        br_valid    = 1'b0;
        ccc         = 3'd0;
        br_imm      = 9'd0;
        br_reg_mode = 1'b0;
        br_reg      = 16'd0;
        pc_in       = 16'd0;
        flag_in     = 3'b000;
        flag_wr_en  = 3'b000;
        last_npc    = 16'd0;
        last_taken  = 1'b0;

        step();
        step();
        check("rst_outputs", {13'd0, res_valid, taken, flush, next_pc}, 32'd0);
        check("rst_ready", 32'(br_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_post_rst", 32'(br_ready), 32'd1);

        // EQ taken, B form: 0x0010 + 2 + 3*2 = 0x0018.
        clear_seq();
        for (int i = 0; i < 8; i++) flg_seq[i] = 3'b100;
        run_txn(3'd1, 9'd3, 1'b0, 16'h0000, 16'h0010);
        check("eq_npc", 32'(last_npc), 32'h0018);
        check("eq_taken", 32'(last_taken), 32'd1);

        // NE with Z=1: not taken, sequential.
        run_txn(3'd0, 9'd3, 1'b0, 16'h0000, 16'h0010);
        check("ne_npc", 32'(last_npc), 32'h0012);

        // LT stalled two cycles on N writes, N=1 at resolution.
        clear_seq();
        wr_seq[0] = 3'b001;
        wr_seq[1] = 3'b001;
        flg_seq[2] = 3'b001;
        run_txn(3'd3, 9'h1FE, 1'b0, 16'h0000, 16'h0100);
        check("lt_taken", 32'(last_taken), 32'd1);
        check("lt_npc", 32'(last_npc), 32'h00FE);

        // OV with writes to Z and N only: no stall.
        clear_seq();
        wr_seq[0]  = 3'b101;
        flg_seq[0] = 3'b010;
        run_txn(3'd6, 9'd0, 1'b0, 16'h0000, 16'h0200);
        check("ov_taken", 32'(last_taken), 32'd1);

        // UNC BR form and B form boundary addresses.
        clear_seq();
        run_txn(3'd7, 9'd5, 1'b1, 16'hABCE, 16'h1234);
        check("unc_br_npc", 32'(last_npc), 32'hABCE);
        run_txn(3'd7, 9'd0, 1'b0, 16'h0000, 16'hFFFC);
        check("unc_b_npc", 32'(last_npc), 32'hFFFE);
        for (int i = 0; i < 8; i++) flg_seq[i] = 3'b100;
        run_txn(3'd0, 9'd7, 1'b0, 16'h0000, 16'hFFFE);
        check("wrap_npc", 32'(last_npc), 32'h0000);

        // Reset while stalled in WAIT aborts the branch.
        br_valid   = 1'b1;
        ccc        = 3'd1;
        br_imm     = 9'd1;
        pc_in      = 16'h0040;
        flag_wr_en = 3'b100;
        step();
        br_valid = 1'b0;
        check("wait_entered", 32'(res_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("ready_in_rst", 32'(br_ready), 32'd0);
        step();
        rst        = 1'b0;
        flag_wr_en = 3'b000;
        #1;
        check("ready_rst_release", 32'(br_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_pulse_after_abort", 32'(res_valid), 32'd0);
        end

        // Randomized branches with random flag-write hazards.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 8; i++) begin
                wr_seq[i]  = ($urandom_range(2) == 0) ? 3'b000 : 3'($urandom);
                flg_seq[i] = 3'($urandom);
            end
            wr_seq[7] = 3'b000;
            run_txn(3'($urandom), 9'($urandom), 1'($urandom_range(1)),
                    16'($urandom), 16'($urandom) & 16'hFFFE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
